sr_lsu: RTL and testbench

Multi-cycle load/store unit that sits directly downstream of the instruction decoder in the schoolRISCV core. It consumes the decoder's memory controls (`dmWe`, `dmRMode`) with the ALU-computed address and store data. It drives a variable-latency word-wide data bus with a req/ack handshake and stalls the core until the access completes. It returns sign- or zero-extended load data for the `memToReg` writeback path.

---
 rtl/sr_lsu_if.sv | 21 ++
 rtl/sr_lsu.sv | 150 +++++++++++++++
 tb/tb_sr_lsu.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_lsu_if.sv
// Word-wide data bus between the load/store unit and memory.
// Uses a req/ack handshake with variable latency.
interface sr_lsu_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/sr_lsu.sv
// Multi-cycle load/store unit for the schoolRISCV core.
// It stalls the core while a bus access is in flight.
// It returns sign- or zero-extended load data when the access retires.
module sr_lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        dmWe,
    input  logic [2:0]  dmRMode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata,
    sr_lsu_if.master    bus
);
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t      state_reg, state_next;
    logic        we_reg;
    logic [2:0]  mode_reg;
    logic [1:0]  offset_reg;
    logic        fault_reg;

    logic        legal_mode, misaligned, access_fault;
    logic [3:0]  access_be;
    logic [31:0] access_wdata;
    logic [31:0] shifted_rdata, load_data;
    logic        start;

    assign start = (state_reg == IDLE) && req;

    // Classify the incoming access: illegal mode or misaligned address faults without touching the bus
    always_comb begin
        if (dmWe)
            legal_mode = dmRMode inside {3'b000, 3'b001, 3'b010};
        else
            legal_mode = !(dmRMode inside {3'b011, 3'b110, 3'b111});
        misaligned = ((dmRMode[1:0] == 2'b01) && addr[0]) ||
                     ((dmRMode[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        access_fault = !legal_mode || misaligned;
    end

    // Byte enables and lane-replicated store data for the incoming access
    always_comb begin
        access_be    = 4'b1111;
        access_wdata = wdata;
        if (dmWe) begin
            case (dmRMode[1:0])
                2'b00: begin
                    access_be    = 4'b0001 << addr[1:0];
                    access_wdata = {4{wdata[7:0]}};
                end
                2'b01: begin
                    access_be    = 4'b0011 << {addr[1], 1'b0};
                    access_wdata = {2{wdata[15:0]}};
                end
                default: begin
                    access_be    = 4'b1111;
                    access_wdata = wdata;
                end
            endcase
        end
    end

    // Align the addressed lane to bit 0, then extend according to the latched mode
    always_comb begin
        shifted_rdata = bus.bus_rdata >> {offset_reg, 3'b000};
        case (mode_reg)
            3'b000:  load_data = {{24{shifted_rdata[7]}},  shifted_rdata[7:0]};
            3'b001:  load_data = {{16{shifted_rdata[15]}}, shifted_rdata[15:0]};
            3'b100:  load_data = {24'd0, shifted_rdata[7:0]};
            3'b101:  load_data = {16'd0, shifted_rdata[15:0]};
            default: load_data = shifted_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic: bus ack is only honoured while in BUS
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req) state_next = access_fault ? DONE : BUS;
            BUS:     if (bus.bus_ack) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Core-facing outputs
    always_comb begin
        stall = start || (state_reg == BUS);
        done  = (state_reg == DONE);
        fault = (state_reg == DONE) && fault_reg;
    end

    // Latch the access attributes needed after the request cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_reg     <= 1'b0;
            mode_reg   <= 3'b000;
            offset_reg <= 2'b00;
            fault_reg  <= 1'b0;
        end else if (start) begin
            we_reg     <= dmWe;
            mode_reg   <= dmRMode;
            offset_reg <= addr[1:0];
            fault_reg  <= access_fault;
        end
    end

    // Registered bus outputs: loaded on entry to BUS and cleared when the ack completes the transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'd0;
            bus.bus_be    <= 4'd0;
            bus.bus_wdata <= 32'd0;
        end else if (start && !access_fault) begin
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= dmWe;
            bus.bus_addr  <= {addr[31:2], 2'b00};
            bus.bus_be    <= access_be;
            bus.bus_wdata <= access_wdata;
        end else if ((state_reg == BUS) && bus.bus_ack) begin
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'd0;
            bus.bus_be    <= 4'd0;
            bus.bus_wdata <= 32'd0;
        end
    end

    // Load result: updated only when a load is acknowledged, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= 32'd0;
        else if ((state_reg == BUS) && bus.bus_ack && !we_reg)
            rdata <= load_data;
    end
endmodule

// File: tb/tb_sr_lsu.sv
// Scoreboard testbench for sr_lsu.
// The stimulus pushes model-derived expectations into queues.
// Independent monitors pop and compare the queued expectations on bus beats and on done pulses.
module tb_sr_lsu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        dmWe = 1'b0;
    logic [2:0]  dmRMode = 3'b000;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        stall, done, fault;
    logic [31:0] rdata;

    sr_lsu_if bus_if();

    sr_lsu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .dmWe    (dmWe),
        .dmRMode (dmRMode),
        .addr    (addr),
        .wdata   (wdata),
        .stall   (stall),
        .done    (done),
        .fault   (fault),
        .rdata   (rdata),
        .bus     (bus_if.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          fault;
        logic [31:0] rdata;
        logic        we;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic [31:0] bwdata;
    } exp_t;

    exp_t        bus_q[$];
    exp_t        res_q[$];
    logic [31:0] model_rdata = 32'd0;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: access size, legality and byte lanes from first principles
    task automatic model(input logic we, input logic [2:0] m, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rword, output exp_t e);
        int n;
        int o;
        bit legal;
        logic [31:0] val;
        e.fault = 1'b0; e.we = we; e.baddr = 32'd0; e.be = 4'd0; e.bwdata = 32'd0;
        case (m[1:0])
            2'b00:   n = 1;
            2'b01:   n = 2;
            2'b10:   n = 4;
            default: n = 0;
        endcase
        if (we) legal = (m == 3'd0) || (m == 3'd1) || (m == 3'd2);
        else    legal = (m == 3'd0) || (m == 3'd1) || (m == 3'd2) || (m == 3'd4) || (m == 3'd5);
        o = int'(a[1:0]);
        if (!legal) e.fault = 1'b1;
        else        e.fault = (o % n) != 0;
        if (!e.fault) begin
            e.baddr = {a[31:2], 2'b00};
            if (we) begin
                for (int i = 0; i < n; i++) e.be[o + i] = 1'b1;
                for (int k = 0; k < 4; k++) e.bwdata[8*k +: 8] = wd[8*(k % n) +: 8];
            end else begin
                e.be = 4'hF;
                val = 32'd0;
                for (int i = 0; i < n; i++) val[8*i +: 8] = rword[8*(o + i) +: 8];
                if (!m[2] && n < 4 && val[8*n - 1])
                    for (int b = 8*n; b < 32; b++) val[b] = 1'b1;
                model_rdata = val;
            end
        end
        e.rdata = model_rdata;
    endtask

    // One memory instruction, with the bus slave answering after lat wait cycles
    task automatic do_access(input logic we, input logic [2:0] m, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rword,
                             input int lat, input bit stray);
        exp_t e;
        int done_cyc;
        model(we, m, a, wd, rword, e);
        res_q.push_back(e);
        if (!e.fault) bus_q.push_back(e);
        done_cyc = e.fault ? 1 : 2 + lat;
        @(posedge clk); #1;
        req = 1'b1; dmWe = we; dmRMode = m; addr = a; wdata = wd;
        for (int cyc = 0; cyc <= done_cyc; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                dmWe = 1'($urandom); dmRMode = 3'($urandom); addr = $urandom; wdata = $urandom;
            end
            bus_if.bus_ack   = (!e.fault && cyc == 1 + lat) || (stray && cyc == 0);
            bus_if.bus_rdata = (!e.fault && cyc == 1 + lat) ? rword : $urandom;
            @(negedge clk);
            chk("stall", 32'(stall), 32'(cyc < done_cyc));
            chk("done_timing", 32'(done), 32'(cyc == done_cyc));
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        req = 1'b0;
        bus_if.bus_ack = 1'($urandom);
        bus_if.bus_rdata = $urandom;
    endtask

    // Bus monitor: every cycle with bus_req high must match the oldest outstanding bus expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_if.bus_req) begin
                chk("bus_req_expected", 32'(bus_q.size() != 0), 32'd1);
                if (bus_q.size() != 0) begin
                    chk("bus_we", 32'(bus_if.bus_we), 32'(bus_q[0].we));
                    chk("bus_addr", bus_if.bus_addr, bus_q[0].baddr);
                    chk("bus_be", 32'(bus_if.bus_be), 32'(bus_q[0].be));
                    if (bus_q[0].we) chk("bus_wdata", bus_if.bus_wdata, bus_q[0].bwdata);
                    if (bus_if.bus_ack) void'(bus_q.pop_front());
                end
            end else begin
                chk("bus_idle_zero", {bus_if.bus_we, bus_if.bus_be, 27'd0},  32'd0);
                chk("bus_idle_addr", bus_if.bus_addr | bus_if.bus_wdata, 32'd0);
            end
        end
    end

    // Result monitor: each done pulse retires the oldest outstanding instruction
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done) begin
                chk("done_expected", 32'(res_q.size() != 0), 32'd1);
                if (res_q.size() != 0) begin
                    e = res_q.pop_front();
                    chk("fault", 32'(fault), 32'(e.fault));
                    chk("rdata", rdata, e.rdata);
                end
            end else begin
                chk("fault_without_done", 32'(fault), 32'd0);
            end
        end
    end

    initial begin
        bus_if.bus_ack = 1'b0;
        bus_if.bus_rdata = 32'd0;

        // Reset state
        #2;
        chk("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_if.bus_we), 32'd0);
        chk("rst_bus_addr", bus_if.bus_addr, 32'd0);
        chk("rst_bus_be", 32'(bus_if.bus_be), 32'd0);
        chk("rst_bus_wdata", bus_if.bus_wdata, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_stall_lo", 32'(stall), 32'd0);
        req = 1'b1; #1;
        chk("rst_stall_hi", 32'(stall), 32'd1);
        req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed cases
        do_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0);
        chk("lw_const", rdata, 32'hDEADBEEF);
        do_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 1'b0);
        chk("lb_const", rdata, 32'hFFFFFF80);
        do_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 1, 1'b0);
        chk("lbu_const", rdata, 32'h00000080);
        do_access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 0, 1'b0);
        chk("lh_const", rdata, 32'hFFFF80FF);
        do_access(1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 0, 1'b0);
        do_access(1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0, 2, 1'b0);
        do_access(1'b1, 3'b010, 32'h102, 32'h11223344, 32'h0, 0, 1'b0);
        do_access(1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 1'b1);
        chk("fault_rdata_held", rdata, 32'hFFFF80FF);
        idle_cycle();
        do_access(1'b0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 4, 1'b1);
        chk("lw_wait_const", rdata, 32'hCAFEF00D);

        // Reset during a bus wait: the access is dropped without a done
        begin
            exp_t e;
            model(1'b0, 3'b010, 32'h200, 32'h0, 32'h0, e);
            bus_q.push_back(e);
            res_q.push_back(e);
            @(posedge clk); #1;
            req = 1'b1; dmWe = 1'b0; dmRMode = 3'b010; addr = 32'h200;
            bus_if.bus_ack = 1'b0;
            repeat (2) begin @(posedge clk); #1; end
            chk("bus_req_before_rst", 32'(bus_if.bus_req), 32'd1);
            #1 rst_n = 1'b0;
            #1;
            chk("rst_async_bus_req", 32'(bus_if.bus_req), 32'd0);
            chk("rst_async_stall", 32'(stall), 32'd1);
            req = 1'b0;
            bus_q.delete();
            res_q.delete();
            model_rdata = 32'd0;
            repeat (2) begin
                @(negedge clk);
                chk("rst_no_done", 32'(done), 32'd0);
            end
            @(posedge clk); #1 rst_n = 1'b1;
            @(negedge clk);
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_bus_req", 32'(bus_if.bus_req), 32'd0);
        end
        do_access(1'b0, 3'b010, 32'h300, 32'h0, 32'h13579BDF, 1, 1'b0);
        chk("post_rst_lw", rdata, 32'h13579BDF);

        // Randomized traffic, mostly aligned and legal with some faults mixed in
        for (int t = 0; t < 250; t++) begin
            logic [2:0] m;
            logic [31:0] a;
            m = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            if (!m[1] && $urandom_range(0, 1) == 1) m[2] = 1'b1;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (m[1:0] == 2'b01) a[0] = 1'b0;
                if (m[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            do_access(1'($urandom), m, a, $urandom, $urandom,
                      $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();
        repeat (3) @(negedge clk);
        chk("res_q_drained", res_q.size(), 32'd0);
        chk("bus_q_drained", bus_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
